// File: rtl/tdc_selftest_sequencer.sv
// Self-test sequencer for one pixel TDC: fires a programmed train of test
// pulses, samples the encoder response after each, and accumulates statistics.
module tdc_selftest_sequencer #(
  parameter int CNT_WIDTH  = 16,
  parameter int ARM_CYCLES = 4
) (
  input  logic                 clk40,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] numPulses,
  input  logic [7:0]           pulsePeriod,
  input  logic [3:0]           hitTimeout,
  input  logic                 hitFlag,
  input  logic [9:0]           Cal_code,
  input  logic                 TOAerrorFlag,
  input  logic                 TOTerrorFlag,
  input  logic                 CalerrorFlag,
  output logic                 tdcEnable,
  output logic                 testMode,
  output logic                 pulse,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [CNT_WIDTH-1:0] hitCount,
  output logic [CNT_WIDTH-1:0] missCount,
  output logic [CNT_WIDTH-1:0] errorCount,
  output logic [9:0]           calMin,
  output logic [9:0]           calMax
);

  localparam int ARM_W = $clog2(ARM_CYCLES + 2);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PULSE,
    S_WAIT_HIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [ARM_W-1:0]     arm_cnt_q, arm_cnt_d;
  logic [8:0]           period_q, period_d;
  logic [3:0]           wait_q, wait_d;
  logic [CNT_WIDTH-1:0] pulses_sent_q, pulses_sent_d;

  logic                 tdc_enable_q, tdc_enable_d;
  logic                 test_mode_q, test_mode_d;
  logic                 pulse_q, pulse_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;
  logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;
  logic [CNT_WIDTH-1:0] error_count_q, error_count_d;
  logic [9:0]           cal_min_q, cal_min_d;
  logic [9:0]           cal_max_q, cal_max_d;

  logic [3:0]           eff_timeout;
  logic [8:0]           gap_target;
  logic                 any_error;
  logic [8:0]           period_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign eff_timeout = (hitTimeout == 4'd0) ? 4'd1 : hitTimeout;
  assign gap_target  = (pulsePeriod < 8'd3) ? 9'd3 : {1'b0, pulsePeriod};
  assign any_error   = TOAerrorFlag | TOTerrorFlag | CalerrorFlag;
  assign period_inc  = (&period_q) ? period_q : period_q + 9'd1;

  always_comb begin
    state_d       = state_q;
    arm_cnt_d     = arm_cnt_q;
    period_d      = period_q;
    wait_d        = wait_q;
    pulses_sent_d = pulses_sent_q;
    tdc_enable_d  = tdc_enable_q;
    test_mode_d   = test_mode_q;
    pulse_d       = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    aborted_d     = aborted_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    error_count_d = error_count_q;
    cal_min_d     = cal_min_q;
    cal_max_d     = cal_max_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          hit_count_d   = '0;
          miss_count_d  = '0;
          error_count_d = '0;
          aborted_d     = 1'b0;
          cal_min_d     = 10'h3FF;
          cal_max_d     = 10'h000;
          pulses_sent_d = '0;
          if (numPulses != '0) begin
            state_d      = S_ARM;
            arm_cnt_d    = ARM_W'(1);
            tdc_enable_d = 1'b1;
            test_mode_d  = 1'b1;
            busy_d       = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_ARM: begin
        if (arm_cnt_q >= ARM_LAST) begin
          state_d       = S_PULSE;
          pulse_d       = 1'b1;
          period_d      = 9'd1;
          pulses_sent_d = sat_inc(pulses_sent_q);
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end

      S_PULSE: begin
        state_d  = S_WAIT_HIT;
        wait_d   = 4'd1;
        period_d = period_inc;
      end

      S_WAIT_HIT: begin
        period_d = period_inc;
        if (hitFlag) begin
          state_d     = S_GAP;
          hit_count_d = sat_inc(hit_count_q);
          if (any_error) begin
            error_count_d = sat_inc(error_count_q);
          end else begin
            if (Cal_code < cal_min_q) cal_min_d = Cal_code;
            if (Cal_code > cal_max_q) cal_max_d = Cal_code;
          end
        end else if (wait_q >= eff_timeout) begin
          state_d      = S_GAP;
          miss_count_d = sat_inc(miss_count_q);
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end

      S_GAP: begin
        // The period timer keeps counting through the hit window, so a long
        // timeout simply makes this a single-cycle gap.
        if (period_q >= gap_target) begin
          if (pulses_sent_q < numPulses) begin
            state_d       = S_PULSE;
            pulse_d       = 1'b1;
            period_d      = 9'd1;
            pulses_sent_d = sat_inc(pulses_sent_q);
          end else begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            tdc_enable_d = 1'b0;
            test_mode_d  = 1'b0;
            busy_d       = 1'b0;
          end
        end else begin
          period_d = period_inc;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides whatever the active states decided, including a hit.
    if (abort && (state_q == S_ARM || state_q == S_PULSE ||
                  state_q == S_WAIT_HIT || state_q == S_GAP)) begin
      state_d       = S_DONE;
      done_d        = 1'b1;
      aborted_d     = 1'b1;
      pulse_d       = 1'b0;
      tdc_enable_d  = 1'b0;
      test_mode_d   = 1'b0;
      busy_d        = 1'b0;
      hit_count_d   = hit_count_q;
      miss_count_d  = miss_count_q;
      error_count_d = error_count_q;
      cal_min_d     = cal_min_q;
      cal_max_d     = cal_max_q;
      pulses_sent_d = pulses_sent_q;
    end
  end

  always_ff @(posedge clk40) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      arm_cnt_q     <= '0;
      period_q      <= '0;
      wait_q        <= '0;
      pulses_sent_q <= '0;
      tdc_enable_q  <= 1'b0;
      test_mode_q   <= 1'b0;
      pulse_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
      error_count_q <= '0;
      cal_min_q     <= 10'h3FF;
      cal_max_q     <= 10'h000;
    end else begin
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
      period_q      <= period_d;
      wait_q        <= wait_d;
      pulses_sent_q <= pulses_sent_d;
      tdc_enable_q  <= tdc_enable_d;
      test_mode_q   <= test_mode_d;
      pulse_q       <= pulse_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
      error_count_q <= error_count_d;
      cal_min_q     <= cal_min_d;
      cal_max_q     <= cal_max_d;
    end
  end

  assign tdcEnable  = tdc_enable_q;
  assign testMode   = test_mode_q;
  assign pulse      = pulse_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign hitCount   = hit_count_q;
  assign missCount  = miss_count_q;
  assign errorCount = error_count_q;
  assign calMin     = cal_min_q;
  assign calMax     = cal_max_q;

endmodule

// File: tb/tb_tdc_selftest_sequencer.sv
// Randomized self-checking bench for tdc_selftest_sequencer; expected pulse
// times and statistics come from a per-pulse arithmetic model.
module tb_tdc_selftest_sequencer;

  logic        clk40 = 1'b0;
  logic        resetn = 1'b0, start = 1'b0, abort = 1'b0, hitFlag = 1'b0;
  logic        TOAerrorFlag = 1'b0, TOTerrorFlag = 1'b0, CalerrorFlag = 1'b0;
  logic [15:0] numPulses = '0;
  logic [7:0]  pulsePeriod = '0;
  logic [3:0]  hitTimeout = '0;
  logic [9:0]  Cal_code = '0;
  logic        tdcEnable, testMode, pulse, busy, done, aborted;
  logic [15:0] hitCount, missCount, errorCount;
  logic [9:0]  calMin, calMax;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int h_arr[16];
  int cal_arr[16];
  int err_arr[16];

  tdc_selftest_sequencer #(.CNT_WIDTH(16), .ARM_CYCLES(4)) dut (
    .clk40(clk40), .resetn(resetn), .start(start), .abort(abort),
    .numPulses(numPulses), .pulsePeriod(pulsePeriod), .hitTimeout(hitTimeout),
    .hitFlag(hitFlag), .Cal_code(Cal_code), .TOAerrorFlag(TOAerrorFlag),
    .TOTerrorFlag(TOTerrorFlag), .CalerrorFlag(CalerrorFlag),
    .tdcEnable(tdcEnable), .testMode(testMode), .pulse(pulse), .busy(busy),
    .done(done), .aborted(aborted), .hitCount(hitCount), .missCount(missCount),
    .errorCount(errorCount), .calMin(calMin), .calMax(calMax)
  );

  always #5 clk40 = ~clk40;
  always @(posedge clk40) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required a finished run");
    $fatal(1, "watchdog");
  end

  task automatic set_pulse(input int i, input int h, input int cal, input int err);
    h_arr[i] = h; cal_arr[i] = cal; err_arr[i] = err;
  endtask

  // One complete run: model the expected timeline, drive responses, compare.
  task automatic run_check(input string name, input int np, input int per, input int tmo,
                           input int ab_pulse, input int ab_off, input bit ab_at_start);
    int eff, p3, t, r, edone, enp, ehit, emiss, eerr, emin, emax;
    int s, rel, seen, last_p, done_rel, k, off;
    bit eab;
    int exp_p[16];
    int res[16];
    eff = (tmo == 0) ? 1 : tmo;
    p3 = (per < 3) ? 3 : per;
    t = 5; ehit = 0; emiss = 0; eerr = 0; emin = 1023; emax = 0; eab = 0;
    enp = np; edone = (np == 0) ? 1 : -1;
    for (int i = 0; i < np; i++) begin
      exp_p[i] = t;
      r = (h_arr[i] >= 1 && h_arr[i] <= eff) ? h_arr[i] : eff;
      res[i] = r;
      if (i == ab_pulse) begin
        edone = t + ab_off + 1; eab = 1; enp = i + 1;
        break;
      end
      if (h_arr[i] >= 1 && h_arr[i] <= eff) begin
        ehit++;
        if (err_arr[i] != 0) eerr++;
        else begin
          if (cal_arr[i] < emin) emin = cal_arr[i];
          if (cal_arr[i] > emax) emax = cal_arr[i];
        end
      end else begin
        emiss++;
      end
      t += (r + 2 > p3) ? r + 2 : p3;
    end
    if (np > 0 && !eab) edone = t;

    numPulses = 16'(np); pulsePeriod = 8'(per); hitTimeout = 4'(tmo);
    @(negedge clk40);
    s = cyc; start = 1'b1; abort = ab_at_start; hitFlag = 1'b0;
    seen = 0; last_p = 0; done_rel = -1;
    for (int n = 0; n < 800 && done_rel < 0; n++) begin
      @(negedge clk40);
      rel = cyc - s;
      start = 1'b0; abort = 1'b0; hitFlag = 1'b0;
      {TOAerrorFlag, TOTerrorFlag, CalerrorFlag} = 3'b000;
      Cal_code = 10'($urandom_range(0, 1023));
      if (pulse) begin
        checks++;
        if (seen >= enp || seen >= 16) begin
          failures++;
          $display("FAIL %s pulse_extra: pulse %0d at cycle %0d, required only %0d pulses", name, seen, rel, enp);
        end else if (rel !== exp_p[seen]) begin
          failures++;
          $display("FAIL %s pulse_time: pulse %0d at cycle %0d, required %0d", name, seen, rel, exp_p[seen]);
        end
        checks++;
        if ({busy, tdcEnable, testMode} !== 3'b111) begin
          failures++;
          $display("FAIL %s run_flags: busy/en/tm=%b, required 111", name, {busy, tdcEnable, testMode});
        end
        seen++; last_p = rel;
      end
      if (done) begin
        done_rel = rel;
        checks++;
        if ({busy, tdcEnable, testMode} !== 3'b000) begin
          failures++;
          $display("FAIL %s done_flags: busy/en/tm=%b, required 000", name, {busy, tdcEnable, testMode});
        end
      end else if (seen == 0) begin
        hitFlag = 1'($urandom_range(0, 1));
      end else if (seen <= 16) begin
        k = seen - 1; off = rel - last_p;
        if (h_arr[k] != 0 && off == h_arr[k]) begin
          hitFlag = 1'b1;
          Cal_code = 10'(cal_arr[k]);
          {TOAerrorFlag, TOTerrorFlag, CalerrorFlag} = 3'(err_arr[k]);
        end else if (off == 0 || off == res[k] + 1) begin
          hitFlag = 1'($urandom_range(0, 1));
          {TOAerrorFlag, TOTerrorFlag, CalerrorFlag} = 3'($urandom_range(0, 7));
        end
        if (k == ab_pulse && off == ab_off) abort = 1'b1;
      end
    end
    hitFlag = 1'b0; abort = 1'b0;
    {TOAerrorFlag, TOTerrorFlag, CalerrorFlag} = 3'b000;

    checks++;
    if (done_rel < 0) begin
      failures++;
      $display("FAIL %s done_timeout: no done within budget, required done at cycle %0d", name, edone);
    end else if (done_rel !== edone) begin
      failures++;
      $display("FAIL %s done_time: done at cycle %0d, required %0d", name, done_rel, edone);
    end
    checks++;
    if (seen !== enp) begin
      failures++;
      $display("FAIL %s pulse_count: %0d pulses, required %0d", name, seen, enp);
    end

    @(negedge clk40);
    checks++;
    if ({done, busy, tdcEnable, testMode, pulse} !== 5'b0) begin
      failures++;
      $display("FAIL %s after_done: done/busy/en/tm/pulse=%b, required 00000", name,
               {done, busy, tdcEnable, testMode, pulse});
    end
    checks++;
    if (hitCount !== 16'(ehit) || missCount !== 16'(emiss) || errorCount !== 16'(eerr)) begin
      failures++;
      $display("FAIL %s counts: hit=%0d miss=%0d err=%0d, required hit=%0d miss=%0d err=%0d",
               name, hitCount, missCount, errorCount, ehit, emiss, eerr);
    end
    checks++;
    if (calMin !== 10'(emin) || calMax !== 10'(emax)) begin
      failures++;
      $display("FAIL %s cal_range: min=%0d max=%0d, required min=%0d max=%0d", name, calMin, calMax, emin, emax);
    end
    checks++;
    if (aborted !== eab) begin
      failures++;
      $display("FAIL %s aborted: %b, required %b", name, aborted, eab);
    end
    $display("run %s np=%0d per=%0d tmo=%0d pulses=%0d done@%0d hit=%0d miss=%0d err=%0d min=%0d max=%0d ab=%b",
             name, np, per, tmo, seen, done_rel, hitCount, missCount, errorCount, calMin, calMax, aborted);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk40);
    checks++;
    if ({tdcEnable, testMode, pulse, busy, done, aborted} !== 6'b0 || hitCount !== 16'd0 ||
        missCount !== 16'd0 || errorCount !== 16'd0 || calMin !== 10'h3FF || calMax !== 10'h000) begin
      failures++;
      $display("FAIL reset_state: flags=%b hit=%0d miss=%0d err=%0d min=%h max=%h, required 0s and min=3ff",
               {tdcEnable, testMode, pulse, busy, done, aborted}, hitCount, missCount, errorCount, calMin, calMax);
    end
    resetn = 1'b1;
    @(negedge clk40);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
    $display("reset checked");
  endtask

  task automatic test_clean();
    set_pulse(0, 2, 500, 0); set_pulse(1, 2, 510, 0); set_pulse(2, 2, 490, 0);
    run_check("clean", 3, 10, 6, -1, 0, 1'b0);
  endtask

  task automatic test_no_response();
    set_pulse(0, 0, 0, 0); set_pulse(1, 0, 0, 0);
    run_check("no_response", 2, 10, 3, -1, 0, 1'b0);
  endtask

  task automatic test_error_filter();
    set_pulse(0, 2, 500, 0); set_pulse(1, 2, 1000, 1); set_pulse(2, 2, 490, 0);
    run_check("error_filter", 3, 10, 6, -1, 0, 1'b0);
  endtask

  task automatic test_abort_race();
    set_pulse(0, 2, 300, 0); set_pulse(1, 2, 300, 0);
    run_check("abort_race", 2, 10, 6, 0, 2, 1'b0);
  endtask

  task automatic test_timeout_gt_period();
    set_pulse(0, 7, 100, 0); set_pulse(1, 7, 200, 0);
    run_check("tmo_gt_period", 2, 3, 8, -1, 0, 1'b0);
  endtask

  task automatic test_zero_pulses();
    run_check("zero_pulses", 0, 10, 6, -1, 0, 1'b0);
  endtask

  task automatic test_start_abort_same_cycle();
    set_pulse(0, 1, 700, 0); set_pulse(1, 0, 0, 0);
    run_check("start_abort", 2, 5, 2, -1, 0, 1'b1);
  endtask

  task automatic test_reset_midrun();
    bit found;
    found = 1'b0;
    numPulses = 16'd3; pulsePeriod = 8'd10; hitTimeout = 4'd6;
    @(negedge clk40);
    start = 1'b1;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk40);
      start = 1'b0;
      if (pulse) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midrun_pulse: no pulse within 20 cycles, required one");
    end
    @(negedge clk40);
    resetn = 1'b0;
    @(negedge clk40);
    checks++;
    if ({tdcEnable, testMode, pulse, busy, done, aborted} !== 6'b0 || hitCount !== 16'd0 ||
        missCount !== 16'd0 || errorCount !== 16'd0 || calMin !== 10'h3FF || calMax !== 10'h000) begin
      failures++;
      $display("FAIL midrun_reset: flags=%b hit=%0d miss=%0d err=%0d min=%h max=%h, required reset values",
               {tdcEnable, testMode, pulse, busy, done, aborted}, hitCount, missCount, errorCount, calMin, calMax);
    end
    resetn = 1'b1;
    @(negedge clk40);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrun_after: done=%b busy=%b, required 0 0", done, busy);
    end
    $display("midrun reset checked");
  endtask

  task automatic test_saturation();
    int seen, last_p, off;
    bit fin;
    seen = 0; last_p = 0; fin = 1'b0;
    numPulses = 16'd2; pulsePeriod = 8'd4; hitTimeout = 4'd2;
    @(negedge clk40);
    start = 1'b1;
    @(negedge clk40);
    start = 1'b0;
    force dut.hit_count_q = 16'hFFFF;
    force dut.miss_count_q = 16'hFFFF;
    force dut.error_count_q = 16'hFFFF;
    @(negedge clk40);
    release dut.hit_count_q;
    release dut.miss_count_q;
    release dut.error_count_q;
    for (int n = 0; n < 60 && !fin; n++) begin
      @(negedge clk40);
      hitFlag = 1'b0; CalerrorFlag = 1'b0;
      if (pulse) begin seen++; last_p = n; end
      if (done) fin = 1'b1;
      off = n - last_p;
      if (seen == 1 && off == 1) begin hitFlag = 1'b1; CalerrorFlag = 1'b1; end
    end
    hitFlag = 1'b0; CalerrorFlag = 1'b0;
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL sat_done: no done within budget, required done");
    end
    @(negedge clk40);
    checks++;
    if (hitCount !== 16'hFFFF || missCount !== 16'hFFFF || errorCount !== 16'hFFFF) begin
      failures++;
      $display("FAIL saturation: hit=%h miss=%h err=%h, required ffff ffff ffff", hitCount, missCount, errorCount);
    end
    $display("saturation run hit=%h miss=%h err=%h", hitCount, missCount, errorCount);
  endtask

  task automatic test_random();
    int np, per, tmo, eff, ab_p, ab_o, r;
    for (int run = 0; run < 8; run++) begin
      np = $urandom_range(1, 6);
      per = $urandom_range(0, 20);
      tmo = $urandom_range(0, 8);
      eff = (tmo == 0) ? 1 : tmo;
      for (int i = 0; i < np; i++) begin
        set_pulse(i, $urandom_range(0, eff), $urandom_range(0, 1023),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
      end
      ab_p = -1; ab_o = 0;
      if ($urandom_range(0, 3) == 0) begin
        ab_p = $urandom_range(0, np - 1);
        r = (h_arr[ab_p] != 0) ? h_arr[ab_p] : eff;
        ab_o = $urandom_range(1, r);
      end
      run_check("random", np, per, tmo, ab_p, ab_o, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_no_response();
    test_error_filter();
    test_abort_race();
    test_timeout_gt_period();
    test_zero_pulses();
    test_start_abort_same_cycle();
    test_reset_midrun();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdc_selftest_sequencer.md
Name: tdc_selftest_sequencer

Overview:
- Autonomous self-test sequencer for one pixel TDC, clocked on clk40.
- Drives the TDC controller inputs (enable, testMode, pulse) and fires a programmed train of test pulses.
- Samples the encoder outputs (hitFlag, codes, error flags) after each pulse and accumulates hit, miss and error statistics plus Cal-code min/max for slow-control readback.

Parameters:
- CNT_WIDTH, 16, width of pulse/hit/miss/error counters.
- ARM_CYCLES, 4, clk40 cycles between TDC enable and first pulse.

Ports:
- clk40  in  1  system clock.
- resetn  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle run request; ignored unless IDLE.
- abort  in  1  terminate run.
- numPulses  in  CNT_WIDTH  pulses per run.
- pulsePeriod  in  8  clk40 cycles between pulse rising cycles.
- hitTimeout  in  4  cycles to wait for hitFlag after a pulse.
- hitFlag  in  1  encoder hit flag.
- Cal_code  in  10  encoder Cal code.
- TOAerrorFlag, TOTerrorFlag, CalerrorFlag  in  1 each  encoder error flags.
- tdcEnable  out  1  TDC enable.
- testMode  out  1  TDC test mode.
- pulse  out  1  test pulse, one cycle wide.
- busy  out  1  run in progress.
- done  out  1  one-cycle end-of-run strobe.
- aborted  out  1  last run ended by abort.
- hitCount, missCount, errorCount  out  CNT_WIDTH  run statistics.
- calMin, calMax  out  10  Cal-code extremes over clean hits.

Behaviour:
- Reset and output timing:
  - All outputs are registered.
  - resetn low at an edge: state IDLE; every output 0 except calMin=10'h3FF; internal timers 0.
  - resetn low mid-run: same values, with no done strobe.
- States: IDLE, ARM, PULSE, WAIT_HIT, GAP, DONE.
- IDLE:
  - start=1 with numPulses!=0 → ARM.
    - Clear hitCount, missCount, errorCount and aborted.
    - Set calMin=3FF, calMax=0.
    - Set tdcEnable=1, testMode=1, busy=1.
  - start=1 with numPulses=0 → DONE with the same clears.
- ARM: hold exactly ARM_CYCLES cycles → PULSE.
- PULSE:
  - pulse=1 for this single cycle.
  - Period timer reset to 1; pulsesSent++.
  - → WAIT_HIT.
- WAIT_HIT: the period timer increments every cycle from PULSE onward. Each cycle:
  - If hitFlag=1 → GAP.
    - hitCount++.
    - If any error flag is set: errorCount++ and min/max are not updated.
    - Otherwise: calMin=min(calMin,Cal_code) and calMax=max(calMax,Cal_code).
  - Else if the wait counter reaches the effective timeout → missCount++, then GAP. The effective timeout is max(hitTimeout,1).
- GAP:
  - Leave when the period timer is ≥ max(pulsePeriod,3), or immediately (after 1 GAP cycle) if already past.
  - Exit target: PULSE if pulsesSent<numPulses, else DONE.
- DONE:
  - done=1 for one cycle.
  - tdcEnable=0, testMode=0, busy=0.
  - → IDLE.
- abort:
  - abort=1 in ARM/PULSE/WAIT_HIT/GAP → DONE next cycle with aborted=1.
  - Abort has priority over a same-cycle hitFlag, which is not counted.
  - abort in IDLE/DONE is ignored.
- Statistics hold until the next accepted start.
- Counters saturate at all-ones; no wrap.
- hitFlag outside WAIT_HIT is ignored; only the first hitFlag per pulse counts.
- start and abort in the same IDLE cycle: start wins, and abort is ignored.
- Inputs numPulses, pulsePeriod and hitTimeout are sampled continuously. Software must hold them stable while busy; behaviour is undefined otherwise.

Test Plan:
- Clean run: numPulses=3, pulsePeriod=10, hitTimeout=6, hitFlag 2 cycles after each pulse with Cal_code 500/510/490 → pulses exactly 10 cycles apart, first pulse 5 cycles after start edge; hitCount=3, missCount=0, errorCount=0, calMin=490, calMax=510; single done, busy low after.
- No response: numPulses=2, hitTimeout=3, hitFlag never asserted → missCount=2, hitCount=0, calMin=3FF, calMax=0.
- Error filtering: as the clean run but CalerrorFlag=1 on hit 2 (Cal_code 1000) → hitCount=3, errorCount=1, calMin=490, calMax=500.
- Abort race: abort and hitFlag together in WAIT_HIT of pulse 1 → hitCount=0, done next cycle, aborted=1, tdcEnable=0, testMode=0.
- Timeout longer than period: pulsePeriod=3, hitTimeout=8, hit 7 cycles after pulse → GAP lasts 1 cycle, next pulse 9 cycles after the previous one.
- Corner cases:
  - numPulses=0 → done one cycle after start, no pulse.
  - resetn low mid-WAIT_HIT → all outputs at reset values next edge, no done.
  - hitCount preloaded path at FFFF (force) → stays FFFF.
